// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: classifies each committed instruction, numbers it,
// and queues the record in a small FIFO that the trace writer drains.
module retire_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      pc,
    input  logic             reg_write,
    input  logic [2:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             halt,
    output logic             full,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [2:0]       rec_kind,
    output logic [CNT_W-1:0] rec_inum,
    output logic [15:0]      rec_pc,
    output logic [15:0]      rec_value,
    output logic [15:0]      rec_addr,
    output logic [15:0]      rec_mdata,
    output logic [2:0]       rec_reg,
    output logic             overflow,
    output logic             halted,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_OCC  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        K_PLAIN = 3'd0,
        K_REG   = 3'd1,
        K_LOAD  = 3'd2,
        K_STORE = 3'd3,
        K_STU   = 3'd4,
        K_HALT  = 3'd5
    } kind_e;

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_DONE} state_e;

    typedef struct packed {
        kind_e            kind;
        logic [CNT_W-1:0] inum;
        logic [15:0]      pc;
        logic [15:0]      value;
        logic [15:0]      addr;
        logic [15:0]      mdata;
        logic [2:0]       rg;
    } rec_t;

    state_e           state, state_nxt;
    logic [AW:0]      wr_ptr, rd_ptr, occupancy;
    logic [CNT_W-1:0] inum_cnt;
    rec_t             mem [DEPTH];
    rec_t             in_rec, head;
    logic             capture_en, push, pop, drop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign occupancy  = wr_ptr - rd_ptr;
    assign full       = (occupancy == FULL_OCC);
    assign rec_valid  = (occupancy != '0);
    assign pop        = rec_valid & rec_ready;
    assign capture_en = in_valid & (state == S_RUN);
    assign push       = capture_en & (~full | pop);
    assign drop       = capture_en & full & ~pop;
    assign halted     = (state != S_RUN);
    assign done       = (state == S_DONE);

    always_comb begin
        // NOTE: every field gets a default first, so no path can infer a latch
        // and fields a kind does not use are stored as zero.
        in_rec      = '0;
        in_rec.pc   = pc;
        in_rec.inum = inum_cnt;
        if (reg_write && mem_write) begin
            in_rec.kind  = K_STU;
            in_rec.rg    = write_reg;
            in_rec.value = write_data;
            in_rec.addr  = mem_addr;
            in_rec.mdata = mem_data;
        end else if (reg_write && mem_read) begin
            in_rec.kind  = K_LOAD;
            in_rec.rg    = write_reg;
            in_rec.value = write_data;
            in_rec.addr  = mem_addr;
        end else if (reg_write) begin
            in_rec.kind  = K_REG;
            in_rec.rg    = write_reg;
            in_rec.value = write_data;
        end else if (halt) begin
            in_rec.kind  = K_HALT;
        end else if (mem_write) begin
            in_rec.kind  = K_STORE;
            in_rec.addr  = mem_addr;
            in_rec.mdata = mem_data;
        end
    end

    // NOTE: the storage array is deliberately not reset; rec_* outputs are
    // masked by rec_valid, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_rec;
    end

    // NOTE: all registered state uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inum_cnt <= '0;
            overflow <= 1'b0;
            state    <= S_RUN;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                inum_cnt <= inum_cnt + 1'b1;
            end
            if (pop)  rd_ptr   <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
            state <= state_nxt;
        end
    end

    // No captures happen once halted, so the pop of the last entry empties the FIFO.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:    if (push && in_rec.kind == K_HALT) state_nxt = S_HALTED;
            S_HALTED: if (pop && occupancy == ONE_OCC)   state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        head      = mem[rd_ptr[AW-1:0]];
        rec_kind  = '0;
        rec_inum  = '0;
        rec_pc    = '0;
        rec_value = '0;
        rec_addr  = '0;
        rec_mdata = '0;
        rec_reg   = '0;
        if (rec_valid) begin
            rec_kind  = head.kind;
            rec_inum  = head.inum;
            rec_pc    = head.pc;
            rec_value = head.value;
            rec_addr  = head.addr;
            rec_mdata = head.mdata;
            rec_reg   = head.rg;
        end
    end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Captures one retirement event per cycle from the single-cycle processor's commit signals, classifies it, tags it with a sequential instruction number, and buffers it in a small FIFO. Sits directly downstream of the processor's write-back/memory commit point and upstream of the trace/log writer, which drains records with a valid/ready handshake. Provides back-pressure (`full`) to the processor and reports halt/drain completion.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `CNT_W`, 16: width of instruction-number counter.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  a retirement event is present this cycle.
- `pc`  in  16  PC of retiring instruction.
- `reg_write`  in  1  register file written.
- `write_reg`  in  3  destination register.
- `write_data`  in  16  register write value.
- `mem_read`  in  1  data memory read.
- `mem_write`  in  1  data memory write.
- `mem_addr`  in  16  data memory address.
- `mem_data`  in  16  data memory write value.
- `halt`  in  1  HALT retiring.
- `full`  out  1  FIFO holds DEPTH entries; processor must stall.
- `rec_valid`  out  1  record at FIFO head is valid.
- `rec_ready`  in  1  consumer accepts head record.
- `rec_kind`  out  3  0 PLAIN, 1 REG, 2 LOAD, 3 STORE, 4 STU, 5 HALT.
- `rec_inum`  out  CNT_W  instruction number.
- `rec_pc`, `rec_value`, `rec_addr`, `rec_mdata`  out  16 each.
- `rec_reg`  out  3.
- `overflow`  out  1  sticky: an event was dropped.
- `halted`  out  1  HALT record captured.
- `done`  out  1  halted and FIFO drained.

## Operation
- Classification priority: reg_write&mem_write→STU; reg_write&mem_read→LOAD; reg_write→REG; halt→HALT; mem_write→STORE; else PLAIN.
- Captured fields: pc, inum always; reg/value for REG/LOAD/STU; addr for LOAD/STORE/STU; mdata for STORE/STU; unused fields stored as 0.
- `inum` = counter value at capture; counter increments by 1 per accepted event, wraps modulo 2^CNT_W.
- State machine: RUN → HALTED on capture of a HALT record; HALTED → DONE when FIFO becomes empty; DONE holds until reset. In HALTED/DONE, `in_valid` ignored (no capture, no counter change, no overflow).
- Dequeue: `rec_valid & rec_ready` pops head.
- Enqueue accepted when `in_valid` in RUN and (occupancy < DEPTH, or a dequeue occurs the same cycle).
- Full, no dequeue, `in_valid` in RUN: event dropped, counter unchanged, `overflow` set (sticky until reset). A dropped HALT does not enter HALTED.
- `rec_*` fields driven 0 whenever `rec_valid`=0.
- Read/write pointers are log2(DEPTH) bits plus wrap bit; occupancy = difference.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): FIFO empty, counter 0, state RUN; `rec_valid`,`full`,`overflow`,`halted`,`done` = 0; all `rec_*` = 0. Reset mid-operation discards all buffered records.
- Latency: event sampled at edge N appears at head no earlier than after edge N (visible in cycle N+1); no combinational input→output bypass.
- `full`, `rec_valid`, `halted`, `done` are functions of registered state only.
- `halted` asserts the cycle after HALT capture; `done` asserts the cycle after the pop that empties the FIFO while HALTED (same cycle as `halted` is impossible, since the HALT record itself must drain).
- `rec_valid` stays asserted with stable fields until popped.
- Simultaneous push and pop at any occupancy: occupancy unchanged, order preserved.

## Test plan
- Reset, then REG event pc=0x0002 reg=3 data=0x1234, rec_ready=1 → next cycle rec_valid=1, kind=1, inum=0, reg=3, value=0x1234; following cycle rec_valid=0.
- Sequence STORE(addr 0x0010, mdata 0xBEEF), LOAD(reg 1, addr 0x0010, data 0xBEEF), STU(reg 2, value 0x0012, addr 0x0012, mdata 0x0007), PLAIN → kinds 3,2,4,0, inums 0..3, unused fields 0.
- rec_ready=0, 8 events (DEPTH=8) → full=1 after 8th; 9th dropped, overflow=1; drain yields inums 0..7; next accepted event gets inum 8.
- Full FIFO with rec_ready=1 and in_valid every cycle → no drop, overflow stays 0, occupancy stays 8, inums contiguous.
- HALT at inum 5 with 2 records queued → halted=1 next cycle; further in_valid ignored; after draining 3 records (last kind=5) done=1.
- Assert rst low mid-stream with 4 records queued → immediately rec_valid=0, full=0, overflow=0; after release first event gets inum 0.
